// File: rtl/mem_stall_ctrl.sv
// Back-pressure controller: one outstanding request per memory port.
// Optional stall counter enabled by MEM_STALL_PERF_CNT_EN.
module mem_stall_ctrl #(
  parameter int NUM_PORTS = 2,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          port_req,
  input  logic [NUM_PORTS-1:0]          port_resp,
  input  logic [NUM_PORTS*DATA_W-1:0]   port_rdata,
  output logic [NUM_PORTS*DATA_W-1:0]   rdata_out,
  output logic                          move,
  output logic [NUM_PORTS-1:0]          busy,
  output logic                          protocol_err,
  output logic [CNT_W-1:0]              stall_cycles
);

  logic [NUM_PORTS-1:0] pending;
  logic [NUM_PORTS-1:0] done;
  logic [NUM_PORTS-1:0] port_ok;
  logic [NUM_PORTS-1:0] accept;
  logic [NUM_PORTS-1:0] bad_resp;
  logic [NUM_PORTS-1:0] bad_req;
  logic [DATA_W-1:0]    held [NUM_PORTS];
  logic                 err;

  // Per-port readiness and error detection
  always_comb begin
    port_ok  = ~pending | port_resp | done;
    accept   = pending & ~done & port_resp;
    bad_resp = port_resp & ~pending;
    bad_req  = port_req & pending & ~{NUM_PORTS{move}};
  end

  assign move         = ~rst & (&port_ok);
  assign busy         = pending & ~done;
  assign protocol_err = err;

  // Live data on a response cycle, otherwise the latched copy
  always_comb begin
    rdata_out = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      rdata_out[i*DATA_W +: DATA_W] = port_resp[i]
        ? port_rdata[i*DATA_W +: DATA_W] : held[i];
    end
  end

  // Per-port IDLE/WAIT/DONE tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      done    <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (move) begin
          pending[i] <= port_req[i];
          done[i]    <= 1'b0;
        end else begin
          if (!pending[i] && port_req[i]) pending[i] <= 1'b1;
          if (accept[i]) done[i] <= 1'b1;
        end
      end
    end
  end

  // Capture response data on every accepted response
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PORTS; i++) held[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (accept[i]) held[i] <= port_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Sticky protocol violation flag
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else if (|bad_resp || |bad_req) err <= 1'b1;
  end

`ifdef MEM_STALL_PERF_CNT_EN
  logic [CNT_W-1:0] cnt;

  // Saturating count of stalled cycles
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (!move && !(&cnt)) cnt <= cnt + 1'b1;
  end

  assign stall_cycles = cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Directed self-checking bench for mem_stall_ctrl.
// Two ports, 32-bit data.
module tb_mem_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  port_req;
  logic [1:0]  port_resp;
  logic [63:0] port_rdata;
  logic [63:0] rdata_out;
  logic        move;
  logic [1:0]  busy;
  logic        protocol_err;
  logic [31:0] stall_cycles;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_stall_ctrl #(.NUM_PORTS(2), .DATA_W(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .port_req(port_req), .port_resp(port_resp),
    .port_rdata(port_rdata), .rdata_out(rdata_out),
    .move(move), .busy(busy),
    .protocol_err(protocol_err), .stall_cycles(stall_cycles)
  );

  task automatic drive(input logic [1:0] rq, input logic [1:0] rs,
                       input logic [31:0] d1, input logic [31:0] d0);
    port_req   = rq;
    port_resp  = rs;
    port_rdata = {d1, d0};
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(2'b00, 2'b00, 32'h0, 32'h0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (move !== 1'b0) begin
        errors++;
        $display("FAIL reset_move got=%b exp=0", move);
      end
      next_cycle();
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (move !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_move got=%b exp=1", move);
    end
    checks++;
    if (busy !== 2'b00 || protocol_err !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_state busy=%b err=%b exp 00/0", busy, protocol_err);
    end
    checks++;
    if (rdata_out !== 64'h0 || stall_cycles !== 32'h0) begin
      errors++;
      $display("FAIL post_reset_data rdata=%h stall=%0d exp 0/0", rdata_out, stall_cycles);
    end
    next_cycle();
  endtask

  task automatic test_single_cycle();
    drive(2'b11, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (move !== 1'b1) begin
      errors++;
      $display("FAIL single_issue_move got=%b exp=1", move);
    end
    next_cycle();
    for (int c = 0; c < 4; c++) begin
      drive((c == 3) ? 2'b00 : 2'b11, 2'b11, 32'hDEADBEEF, 32'h00000013);
      @(negedge clk);
      checks++;
      if (move !== 1'b1 || rdata_out !== 64'hDEADBEEF_00000013) begin
        errors++;
        $display("FAIL single_cycle move=%b rdata=%h exp 1/deadbeef00000013", move, rdata_out);
      end
      next_cycle();
    end
    drive(2'b00, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (busy !== 2'b00 || stall_cycles !== 32'h0) begin
      errors++;
      $display("FAIL single_end busy=%b stall=%0d exp 00/0", busy, stall_cycles);
    end
    next_cycle();
  endtask

  task automatic test_skewed();
    logic [31:0] exp_stall;
`ifdef MEM_STALL_PERF_CNT_EN
    exp_stall = 32'd3;
`else
    exp_stall = 32'd0;
`endif
    drive(2'b11, 2'b00, 32'h0, 32'h0);
    next_cycle();
    drive(2'b00, 2'b01, 32'h0, 32'h00A00093);
    @(negedge clk);
    checks++;
    if (move !== 1'b0 || rdata_out[31:0] !== 32'h00A00093) begin
      errors++;
      $display("FAIL skew_first move=%b r0=%h exp 0/00a00093", move, rdata_out[31:0]);
    end
    next_cycle();
    for (int c = 0; c < 2; c++) begin
      drive(2'b00, 2'b00, 32'h0, 32'hFFFFFFFF);
      @(negedge clk);
      checks++;
      if (move !== 1'b0 || rdata_out[31:0] !== 32'h00A00093 || busy !== 2'b10) begin
        errors++;
        $display("FAIL skew_wait move=%b r0=%h busy=%b exp 0/00a00093/10",
                 move, rdata_out[31:0], busy);
      end
      next_cycle();
    end
    drive(2'b00, 2'b10, 32'h12345678, 32'h0);
    @(negedge clk);
    checks++;
    if (move !== 1'b1 || rdata_out !== 64'h12345678_00A00093) begin
      errors++;
      $display("FAIL skew_done move=%b rdata=%h exp 1/1234567800a00093", move, rdata_out);
    end
    next_cycle();
    drive(2'b00, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (busy !== 2'b00 || stall_cycles !== exp_stall) begin
      errors++;
      $display("FAIL skew_stall busy=%b stall=%0d exp 00/%0d", busy, stall_cycles, exp_stall);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    drive(2'b01, 2'b00, 32'h0, 32'h0);
    next_cycle();
    drive(2'b01, 2'b01, 32'h0, 32'h11111111);
    @(negedge clk);
    checks++;
    if (move !== 1'b1) begin
      errors++;
      $display("FAIL b2b_move got=%b exp=1", move);
    end
    next_cycle();
    drive(2'b00, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (busy !== 2'b01 || protocol_err !== 1'b0 || rdata_out[31:0] !== 32'h11111111) begin
      errors++;
      $display("FAIL b2b_wait busy=%b err=%b r0=%h exp 01/0/11111111",
               busy, protocol_err, rdata_out[31:0]);
    end
    next_cycle();
    drive(2'b00, 2'b01, 32'h0, 32'h22222222);
    next_cycle();
    drive(2'b00, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (busy !== 2'b00 || rdata_out[31:0] !== 32'h22222222) begin
      errors++;
      $display("FAIL b2b_end busy=%b r0=%h exp 00/22222222", busy, rdata_out[31:0]);
    end
    next_cycle();
  endtask

  task automatic test_protocol();
    drive(2'b00, 2'b10, 32'h00000BAD, 32'h0);
    next_cycle();
    drive(2'b00, 2'b00, 32'h0, 32'h0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (protocol_err !== 1'b1 || rdata_out[63:32] !== 32'h12345678 || busy !== 2'b00) begin
        errors++;
        $display("FAIL err_idle_resp err=%b r1=%h busy=%b exp 1/12345678/00",
                 protocol_err, rdata_out[63:32], busy);
      end
      next_cycle();
    end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (protocol_err !== 1'b0) begin
      errors++;
      $display("FAIL err_cleared got=%b exp=0", protocol_err);
    end
    drive(2'b01, 2'b00, 32'h0, 32'h0);
    next_cycle();
    drive(2'b01, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (move !== 1'b0) begin
      errors++;
      $display("FAIL err_wait_move got=%b exp=0", move);
    end
    next_cycle();
    drive(2'b00, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (protocol_err !== 1'b1 || busy !== 2'b01) begin
      errors++;
      $display("FAIL err_req_wait err=%b busy=%b exp 1/01", protocol_err, busy);
    end
  endtask

  task automatic test_reset_mid_stall();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (move !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_move got=%b exp=0", move);
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 2'b00 || protocol_err !== 1'b0 || rdata_out !== 64'h0
        || stall_cycles !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_state busy=%b err=%b rdata=%h stall=%0d exp 00/0/0/0",
               busy, protocol_err, rdata_out, stall_cycles);
    end
    checks++;
    if (move !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_after got=%b exp=1", move);
    end
    next_cycle();
  endtask

  initial begin
    rst = 1'b1;
    drive(2'b00, 2'b00, 32'h0, 32'h0);
    #1;
    test_reset();
    test_single_cycle();
    test_skewed();
    test_back_to_back();
    test_protocol();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
